// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the FiveSPCPU unified-memory arbiter: FSM states, port
// ownership encoding and latency defaults.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    localparam int MEM_LAT_DEFAULT = 2;

    // Bits needed to hold a down-counter that starts at n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory-side signals of the arbiter.
// slave = arbiter view, master = CPU/memory side view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// Memory latency down-counter: loads MEM_LAT-1 at grant time and reports
// done once it has reached zero.
module mem_lat_counter
    import cpu_mem_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_done
);

    localparam int            CW       = cnt_width(MEM_LAT);
    localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LAT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store,
// favouring data accesses but forcing a fetch after FAIR_LIMIT data grants.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int MEM_LAT    = MEM_LAT_DEFAULT,
    parameter int FAIR_LIMIT = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    mem_port_arbiter_if.slave bus
);

    localparam int            SW         = (FAIR_LIMIT > 0) ? $clog2(FAIR_LIMIT + 1) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(FAIR_LIMIT);
    localparam bit            FAIR_EN    = (FAIR_LIMIT != 0);

    state_t            r_state,     w_state_next;
    owner_t            r_owner,     w_owner_next;
    logic [SW-1:0]     r_streak,    w_streak_next;
    logic              r_mem_en,    w_mem_en_next;
    logic              r_mem_we,    w_mem_we_next;
    logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_next;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_next;
    logic [DATA_W-1:0] r_if_rdata,  w_if_rdata_next;
    logic [DATA_W-1:0] r_dm_rdata,  w_dm_rdata_next;
    logic              r_if_ready,  w_if_ready_next;
    logic              r_dm_ready,  w_dm_ready_next;
    logic              r_busy,      w_busy_next;

    logic w_cnt_load;
    logic w_cnt_en;
    logic w_cnt_done;
    logic w_grant_if;

    mem_lat_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_cnt (
        .i_clk  (CLK),
        .i_rst  (Reset),
        .i_load (w_cnt_load),
        .i_en   (w_cnt_en),
        .o_done (w_cnt_done)
    );

    always_comb begin
        w_state_next     = r_state;
        w_owner_next     = r_owner;
        w_streak_next    = r_streak;
        w_mem_en_next    = r_mem_en;
        w_mem_we_next    = r_mem_we;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        w_if_rdata_next  = r_if_rdata;
        w_dm_rdata_next  = r_dm_rdata;
        w_if_ready_next  = 1'b0;
        w_dm_ready_next  = 1'b0;
        w_cnt_load       = 1'b0;
        w_cnt_en         = 1'b0;
        w_grant_if       = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    // Fetch wins only when alone or when its wait has hit the fairness limit.
                    w_grant_if       = bus.if_req &&
                                       (!bus.dm_req || (FAIR_EN && (r_streak == STREAK_MAX)));
                    w_owner_next     = w_grant_if ? OWN_IF : OWN_DM;
                    w_mem_addr_next  = w_grant_if ? bus.if_addr : bus.dm_addr;
                    w_mem_we_next    = !w_grant_if && bus.dm_we;
                    w_mem_wdata_next = w_grant_if ? '0 : bus.dm_wdata;
                    w_mem_en_next    = 1'b1;
                    w_cnt_load       = 1'b1;
                    w_state_next     = ACCESS;
                    if (w_grant_if || !bus.if_req) begin
                        w_streak_next = '0;
                    end else if (r_streak != STREAK_MAX) begin
                        w_streak_next = r_streak + SW'(1);
                    end
                end
            end
            ACCESS: begin
                w_cnt_en = 1'b1;
                if (w_cnt_done) begin
                    w_mem_en_next = 1'b0;
                    w_mem_we_next = 1'b0;
                    w_state_next  = DONE;
                    if (r_owner == OWN_IF) begin
                        w_if_rdata_next = bus.mem_rdata;
                        w_if_ready_next = 1'b1;
                    end else begin
                        if (!r_mem_we) begin
                            w_dm_rdata_next = bus.mem_rdata;
                        end
                        w_dm_ready_next = 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        w_busy_next = (w_state_next != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_owner     <= OWN_IF;
            r_streak    <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_ready  <= 1'b0;
            r_dm_ready  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_owner     <= w_owner_next;
            r_streak    <= w_streak_next;
            r_mem_en    <= w_mem_en_next;
            r_mem_we    <= w_mem_we_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_if_rdata  <= w_if_rdata_next;
            r_dm_rdata  <= w_dm_rdata_next;
            r_if_ready  <= w_if_ready_next;
            r_dm_ready  <= w_dm_ready_next;
            r_busy      <= w_busy_next;
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.if_ready  = r_if_ready;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.dm_ready  = r_dm_ready;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with FAIR_LIMIT=4 and one
// with strict data priority, each backed by a small memory model.
module tb_mem_port_arbiter;
    import cpu_mem_pkg::*;

    logic CLK = 1'b0;
    logic Reset;
    always #5 CLK = ~CLK;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus  ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();

    mem_port_arbiter #(.MEM_LAT(2), .FAIR_LIMIT(4), .ADDR_W(32), .DATA_W(32)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    mem_port_arbiter #(.MEM_LAT(2), .FAIR_LIMIT(0), .ADDR_W(32), .DATA_W(32)) dut0 (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus0)
    );

    // Memory behind dut: registered read, one cycle of latency per enabled cycle.
    logic [31:0] mem [0:63];
    logic [31:0] r_rdata;
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;

    always @(posedge CLK) begin
        if (pl_en) mem[pl_addr[7:2]] <= pl_data;
        else if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        if (bus.mem_en && !bus.mem_we) r_rdata <= mem[bus.mem_addr[7:2]];
    end
    assign bus.mem_rdata  = r_rdata;
    assign bus0.mem_rdata = 32'hA5A5_0000 ^ bus0.mem_addr;

    typedef struct packed {
        logic        owner;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   n_if0   = 0;
    int   n_dm0   = 0;
    logic pulsed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic owner, input logic [31:0] data);
        exp_t e;
        e.owner = owner;
        e.data  = data;
        sb.push_back(e);
    endtask

    // Advance one cycle, sample at +1, and score any completion pulse of dut.
    task automatic step();
        exp_t e;
        @(posedge CLK);
        #1;
        cyc++;
        if (bus0.if_ready) n_if0++;
        if (bus0.dm_ready) n_dm0++;
        pulsed = bus.if_ready | bus.dm_ready;
        if (pulsed) begin
            chk("dual_ready", {31'b0, bus.if_ready & bus.dm_ready}, 32'd0);
            chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("grant_owner", {31'b0, bus.dm_ready}, {31'b0, e.owner});
                chk("ready_rdata", bus.dm_ready ? bus.dm_rdata : bus.if_rdata, e.data);
            end
            $display("cyc %0d: ready if=%b dm=%b rdata=0x%08h", cyc, bus.if_ready,
                     bus.dm_ready, bus.dm_ready ? bus.dm_rdata : bus.if_rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int last;
        Reset = 1'b1;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        bus.if_req  = 1'b0; bus.if_addr  = '0; bus.dm_req  = 1'b0; bus.dm_we  = 1'b0;
        bus.dm_addr = '0;   bus.dm_wdata = '0;
        bus0.if_req  = 1'b0; bus0.if_addr  = '0; bus0.dm_req = 1'b0; bus0.dm_we = 1'b0;
        bus0.dm_addr = '0;   bus0.dm_wdata = '0;

        step();
        pl_en = 1'b1; pl_addr = 8'h10; pl_data = 32'hDEAD_BEEF;
        step();
        pl_en = 1'b0;
        step();

        // Reset state
        chk("rst_mem_en",   {31'b0, bus.mem_en},   32'd0);
        chk("rst_mem_we",   {31'b0, bus.mem_we},   32'd0);
        chk("rst_mem_addr", bus.mem_addr,          32'd0);
        chk("rst_busy",     {31'b0, bus.busy},     32'd0);
        chk("rst_if_ready", {31'b0, bus.if_ready}, 32'd0);
        chk("rst_dm_ready", {31'b0, bus.dm_ready}, 32'd0);
        chk("rst_if_rdata", bus.if_rdata,          32'd0);
        chk("rst_dm_rdata", bus.dm_rdata,          32'd0);
        chk("rst_busy0",    {31'b0, bus0.busy},    32'd0);

        // Single fetch
        Reset = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        push_exp(OWN_IF, 32'hDEAD_BEEF);
        step();
        chk("fetch_en_t1",   {31'b0, bus.mem_en}, 32'd1);
        chk("fetch_busy_t1", {31'b0, bus.busy},   32'd1);
        chk("fetch_addr_t1", bus.mem_addr,        32'h10);
        chk("fetch_we_t1",   {31'b0, bus.mem_we}, 32'd0);
        step();
        chk("fetch_en_t2",   {31'b0, bus.mem_en}, 32'd1);
        step();
        chk("fetch_ready_t3", {31'b0, bus.if_ready}, 32'd1);
        chk("fetch_en_t3",    {31'b0, bus.mem_en},   32'd0);
        bus.if_req = 1'b0;
        step();
        chk("fetch_busy_t4",  {31'b0, bus.busy},     32'd0);
        chk("fetch_ready_t4", {31'b0, bus.if_ready}, 32'd0);

        // Store then load at the same address
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h40; bus.dm_wdata = 32'h1234_5678;
        push_exp(OWN_DM, 32'h0);
        for (int i = 1; i <= 7; i++) begin
            step();
            chk("mem_we_seq", {31'b0, bus.mem_we}, 32'(i <= 2));
            if (i == 3) begin
                chk("store_ready", {31'b0, bus.dm_ready}, 32'd1);
                bus.dm_we = 1'b0;
                push_exp(OWN_DM, 32'h1234_5678);
            end
            if (i == 7) begin
                chk("load_ready", {31'b0, bus.dm_ready}, 32'd1);
                bus.dm_req = 1'b0;
            end
        end
        step();
        chk("ls_busy_idle", {31'b0, bus.busy}, 32'd0);

        // Contention with FAIR_LIMIT = 4
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        bus.dm_req = 1'b1; bus.dm_we   = 1'b0; bus.dm_addr = 32'h40;
        for (int k = 0; k < 7; k++) begin
            if (k == 4) push_exp(OWN_IF, 32'hDEAD_BEEF);
            else        push_exp(OWN_DM, 32'h1234_5678);
        end
        cnt = 0; last = 0;
        for (int i = 0; i < 40 && cnt < 7; i++) begin
            step();
            if (pulsed) begin
                if (cnt > 0) chk("grant_spacing", 32'(cyc - last), 32'd4);
                last = cyc;
                cnt++;
            end
        end
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
        chk("contention_grants", 32'(cnt), 32'd7);
        chk("contention_sb_drained", 32'(sb.size()), 32'd0);
        sb.delete();
        step();

        // Reset in the second ACCESS cycle of a load
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h40;
        step();
        step();
        Reset = 1'b1;
        step();
        chk("midrst_mem_en",   {31'b0, bus.mem_en},   32'd0);
        chk("midrst_busy",     {31'b0, bus.busy},     32'd0);
        chk("midrst_dm_ready", {31'b0, bus.dm_ready}, 32'd0);
        chk("midrst_dm_rdata", bus.dm_rdata,          32'd0);
        step();
        Reset = 1'b0;
        push_exp(OWN_DM, 32'h1234_5678);
        step();
        chk("regrant_mem_en", {31'b0, bus.mem_en}, 32'd1);
        step();
        step();
        chk("regrant_ready", {31'b0, bus.dm_ready}, 32'd1);
        bus.dm_req = 1'b0;
        step();

        // Request dropped during ACCESS
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h10;
        push_exp(OWN_DM, 32'hDEAD_BEEF);
        step();
        bus.dm_req = 1'b0;
        step();
        step();
        chk("drop_ready", {31'b0, bus.dm_ready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("drop_busy",   {31'b0, bus.busy},   32'd0);
            chk("drop_mem_en", {31'b0, bus.mem_en}, 32'd0);
        end

        // Strict data priority (FAIR_LIMIT = 0)
        n_if0 = 0; n_dm0 = 0;
        bus0.if_req = 1'b1; bus0.if_addr = 32'h20;
        bus0.dm_req = 1'b1; bus0.dm_we   = 1'b0; bus0.dm_addr = 32'h80;
        for (int i = 0; i < 19; i++) begin
            step();
            if (bus0.dm_ready) chk("fl0_rdata", bus0.dm_rdata, 32'hA5A5_0080);
        end
        bus0.if_req = 1'b0; bus0.dm_req = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("fl0_if_ready_count", 32'(n_if0), 32'd0);
        chk("fl0_dm_ready_count", 32'(n_dm0), 32'd5);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
